// File: rtl/pid_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pid_cfg_pkg
//   Shared definitions for the PID gain configuration controller:
//   register address map, controller FSM state encoding, default gain width
//   and an address-decode helper.
// -----------------------------------------------------------------------------
package pid_cfg_pkg;

    localparam int GAIN_W_DEF = 6;

    // Register address map seen by the I2C slave.
    localparam logic [7:0] ADDR_KP = 8'h00;
    localparam logic [7:0] ADDR_KI = 8'h01;
    localparam logic [7:0] ADDR_KD = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // nothing staged
        ST_ARMED  = 2'd1,  // shadow holds uncommitted gains, waiting for a safe tick
        ST_COMMIT = 2'd2   // new active gains just appeared
    } cfg_state_t;

    function automatic logic is_gain_addr(input logic [7:0] addr);
        return (addr == ADDR_KP) || (addr == ADDR_KI) || (addr == ADDR_KD);
    endfunction

endpackage

// File: rtl/gain_shadow_reg.sv
// -----------------------------------------------------------------------------
// gain_shadow_reg
//   One gain slot: a shadow register loaded by I2C writes, an active register
//   driven to the PID datapath, and a pending flag meaning "shadow not yet
//   committed". A commit copies shadow to active only when pending is set.
//   A load in the same cycle as a commit restages: the commit uses the old
//   shadow value and pending stays set for the new one.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   load        stage load_data into the shadow (already qualified by enable)
//   load_data   value to stage
//   commit      copy shadow to active if pending (already qualified by enable)
//   active      committed gain
//   pending     shadow differs from committed value
// -----------------------------------------------------------------------------
module gain_shadow_reg #(
    parameter int                  W    = 6,
    parameter logic [W-1:0]        INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         commit,
    output logic [W-1:0] active,
    output logic         pending
);

    logic [W-1:0] shadow;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, which is what makes a same-cycle load and
    // commit pick up the old shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= INIT;
            active  <= INIT;
            pending <= 1'b0;
        end else begin
            if (commit && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pid_gain_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// pid_gain_cfg_ctrl
//   Configuration controller between the I2C slave and the PID datapath.
//   Completed gain writes are staged into per-gain shadow registers and only
//   committed to the active gains at a PID sample tick while the datapath is
//   idle, so gains never change mid-computation. Also provides a registered
//   read-back of the active gains, a sticky stall error when a commit waits
//   too long, and a saturating count of writes to unmapped addresses.
// Optional feature
//   GAIN_CLAMP_EN  when defined, staged values are clamped to GAIN_MAX.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             block enable; low holds all state and ignores strobes/ticks
//   wr_strobe       one-cycle pulse: one gain write complete
//   wr_addr/wr_data target register and value of that write
//   rd_addr         register selected for read-back
//   sample_tick     one-cycle pulse at the PID sample boundary
//   pid_busy        datapath mid-computation; commits are refused
//   err_clr         clears stall_err and addr_err_cnt
//   k_p, k_i, k_d   active gains
//   rd_data         active gain at rd_addr (one cycle later), 0 if unmapped
//   pending         {D,I,P} uncommitted flags
//   commit_pulse    high the cycle new active gains appear
//   stall_err       sticky: a commit waited longer than MAX_WAIT cycles
//   addr_err_cnt    saturating count of writes to unmapped addresses
// -----------------------------------------------------------------------------
module pid_gain_cfg_ctrl
    import pid_cfg_pkg::*;
#(
    parameter int                  GAIN_W   = GAIN_W_DEF,
    parameter logic [GAIN_W-1:0]   KP_INIT  = '0,
    parameter logic [GAIN_W-1:0]   KI_INIT  = '0,
    parameter logic [GAIN_W-1:0]   KD_INIT  = '0,
    parameter int                  MAX_WAIT = 1023,
    parameter logic [GAIN_W-1:0]   GAIN_MAX = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_strobe,
    input  logic [7:0]        wr_addr,
    input  logic [GAIN_W-1:0] wr_data,
    input  logic [7:0]        rd_addr,
    input  logic              sample_tick,
    input  logic              pid_busy,
    input  logic              err_clr,
    output logic [GAIN_W-1:0] k_p,
    output logic [GAIN_W-1:0] k_i,
    output logic [GAIN_W-1:0] k_d,
    output logic [GAIN_W-1:0] rd_data,
    output logic [2:0]        pending,
    output logic              commit_pulse,
    output logic              stall_err,
    output logic [3:0]        addr_err_cnt
);

    localparam int                CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(MAX_WAIT);

`ifdef GAIN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    cfg_state_t        state, state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wr_fire;
    logic              bad_wr;
    logic [2:0]        load_vec;
    logic              commit_en;
    logic [GAIN_W-1:0] staged_data;
    logic [GAIN_W-1:0] rd_mux;

    assign wr_fire  = ena && wr_strobe;
    assign bad_wr   = wr_fire && !is_gain_addr(wr_addr);
    assign load_vec = {wr_fire && (wr_addr == ADDR_KD),
                       wr_fire && (wr_addr == ADDR_KI),
                       wr_fire && (wr_addr == ADDR_KP)};

    // Commit is decided in ARMED; the active registers load on that same edge
    // so new gains are visible the cycle after the tick, while the FSM sits
    // in COMMIT for that cycle.
    assign commit_en = ena && (state == ST_ARMED) && sample_tick && !pid_busy;

    assign staged_data = (CLAMP_EN && (wr_data > GAIN_MAX)) ? GAIN_MAX : wr_data;

    gain_shadow_reg #(.W(GAIN_W), .INIT(KP_INIT)) u_kp (
        .clk(clk), .rst_n(rst_n), .load(load_vec[0]), .load_data(staged_data),
        .commit(commit_en), .active(k_p), .pending(pending[0])
    );

    gain_shadow_reg #(.W(GAIN_W), .INIT(KI_INIT)) u_ki (
        .clk(clk), .rst_n(rst_n), .load(load_vec[1]), .load_data(staged_data),
        .commit(commit_en), .active(k_i), .pending(pending[1])
    );

    gain_shadow_reg #(.W(GAIN_W), .INIT(KD_INIT)) u_kd (
        .clk(clk), .rst_n(rst_n), .load(load_vec[2]), .load_data(staged_data),
        .commit(commit_en), .active(k_d), .pending(pending[2])
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (|load_vec) state_next = ST_ARMED;
            ST_ARMED:  if (commit_en) state_next = ST_COMMIT;
            // Bits still pending here were restaged during the commit decision.
            ST_COMMIT: state_next = (|load_vec || |pending) ? ST_ARMED : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (!ena) state_next = state;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_KP: rd_mux = k_p;
            ADDR_KI: rd_mux = k_i;
            ADDR_KD: rd_mux = k_d;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            stall_err    <= 1'b0;
            addr_err_cnt <= '0;
            commit_pulse <= 1'b0;
            rd_data      <= '0;
        end else if (ena) begin
            state        <= state_next;
            commit_pulse <= commit_en;
            rd_data      <= rd_mux;

            // Counts time spent ARMED; saturates at the limit since the
            // error is sticky and no forced commit happens.
            if (state != ST_ARMED) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (err_clr) begin
                stall_err <= 1'b0;
            end else if ((state == ST_ARMED) && (wait_cnt == WAIT_LIM)) begin
                stall_err <= 1'b1;
            end

            if (err_clr) begin
                addr_err_cnt <= '0;
            end else if (bad_wr && (addr_err_cnt != 4'hF)) begin
                addr_err_cnt <= addr_err_cnt + 4'd1;
            end
        end else begin
            // A pulse must not stretch while the block is disabled.
            commit_pulse <= 1'b0;
        end
    end

endmodule
